pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, stall, flush and forwarding control for a 5-stage in-order pipeline.
// Latency: control outputs are combinational from stage state and inputs; stage tags advance one stage per clk.
// Backpressure: ex_busy freezes PC, IF/ID and ID/EX and bubbles EX/MEM; RAW/load-use hazards hold PC and IF/ID and bubble ID/EX.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_valid                      fetch has a valid instruction for IF/ID
//   id_rs1/id_rs2 (+ _used)       source registers of the instruction in ID
//   id_rd, id_reg_write, id_is_load  destination info of the instruction in ID
//   ex_branch_taken, ex_busy      EX redirect / EX multi-cycle hold
//   pc_we, if_id_we               PC and IF/ID update enables
//   if_id_flush, id_ex_flush      load a bubble into IF/ID / ID/EX
//   stage_valid                   {MEM/WB, EX/MEM, ID/EX, IF/ID} valid bits
//   fwd_a_sel, fwd_b_sel          00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_count, retire_count     saturating performance counters
//
// Build option: define PIPELINE_CTRL_FORWARDING_EN to enable operand forwarding
// (only load-use stalls remain). Without it every RAW dependency stalls until the
// producer has left MEM/WB.
//
// Forward selects are computed for the instruction in ID and are meant to be
// captured alongside it into ID/EX. A producer currently in ID/EX will sit in
// EX/MEM when the consumer executes (select 01); a producer currently in EX/MEM
// will sit in MEM/WB (select 10).

module pipeline_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              ex_busy,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [3:0]        stage_valid,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              ld;
  } stg_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic ifid_vld;
  stg_t id_stage;
  stg_t id_ex;
  stg_t ex_mem;
  stg_t mem_wb;

  logic hit_idex_a, hit_idex_b, hit_exmem_a, hit_exmem_b;
  logic raw_stall;

  // A producer only matches when it is a real register write to a non-zero rd.
  function automatic logic src_hit(input stg_t s, input logic [REG_AW-1:0] rs, input logic used);
    return s.vld && s.rw && (s.rd != '0) && used && (s.rd == rs);
  endfunction

  // Tags for the instruction in ID; a bubble carries all-zero fields.
  always_comb begin
    id_stage     = '0;
    id_stage.vld = ifid_vld;
    if (ifid_vld) begin
      id_stage.rd = id_rd;
      id_stage.rw = id_reg_write;
      id_stage.ld = id_is_load;
    end
  end

  // An empty ID stage cannot create a dependency.
  assign hit_idex_a  = ifid_vld && src_hit(id_ex,  id_rs1, id_rs1_used);
  assign hit_idex_b  = ifid_vld && src_hit(id_ex,  id_rs2, id_rs2_used);
  assign hit_exmem_a = ifid_vld && src_hit(ex_mem, id_rs1, id_rs1_used);
  assign hit_exmem_b = ifid_vld && src_hit(ex_mem, id_rs2, id_rs2_used);

`ifdef PIPELINE_CTRL_FORWARDING_EN
  // Load data is not available in time to forward from EX/MEM, so a load in
  // ID/EX feeding the ID instruction costs one bubble.
  assign raw_stall = id_ex.ld && (hit_idex_a || hit_idex_b);

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (hit_idex_a)       fwd_a_sel = 2'b01;
    else if (hit_exmem_a) fwd_a_sel = 2'b10;
    if (hit_idex_b)       fwd_b_sel = 2'b01;
    else if (hit_exmem_b) fwd_b_sel = 2'b10;
  end
`else
  logic hit_memwb_a, hit_memwb_b;

  assign hit_memwb_a = ifid_vld && src_hit(mem_wb, id_rs1, id_rs1_used);
  assign hit_memwb_b = ifid_vld && src_hit(mem_wb, id_rs2, id_rs2_used);

  // No bypass network: wait until the producer has fully written back.
  assign raw_stall = hit_idex_a || hit_idex_b || hit_exmem_a || hit_exmem_b ||
                     hit_memwb_a || hit_memwb_b;

  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  // Priority: busy > taken branch > RAW stall > advance. In reset the
  // enables sit at their pass-through values regardless of inputs.
  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      if (ex_busy) begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (raw_stall) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_vld     <= 1'b0;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
      stall_count  <= '0;
      retire_count <= '0;
    end else begin
      if (if_id_flush)   ifid_vld <= 1'b0;
      else if (if_id_we) ifid_vld <= if_valid;

      if (id_ex_flush)   id_ex <= '0;
      else if (!ex_busy) id_ex <= id_stage;

      // While EX is busy its result is not ready, so EX/MEM takes a bubble.
      ex_mem <= ex_busy ? '0 : id_ex;
      mem_wb <= ex_mem;

      if (!pc_we && (stall_count != '1))
        stall_count <= stall_count + CNT_ONE;
      if (mem_wb.vld && (retire_count != '1))
        retire_count <= retire_count + CNT_ONE;
    end
  end

  assign stage_valid = {mem_wb.vld, ex_mem.vld, id_ex.vld, ifid_vld};

  // Tag bits kept for visibility that no hazard path needs in every build.
  logic unused_tags;
  assign unused_tags = ^{id_ex.ld, ex_mem.ld, mem_wb.rd, mem_wb.rw, mem_wb.ld};

endmodule
